// File: rtl/vga_frame_monitor.sv
// Sink-side VGA monitor: recovers line/frame timing from the generator bus, measures geometry and
// a per-frame pixel checksum, and publishes coherent per-frame snapshots over an Avalon-MM read slave.
module vga_frame_monitor #(
    parameter int unsigned PIX_W  = 11,
    parameter int unsigned LINE_W = 10,
    parameter int unsigned CSUM_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_clk,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    input  logic        chipselect,
    input  logic        read,
    input  logic [3:0]  address,
    output logic [15:0] readdata
);

    localparam logic [PIX_W-1:0]  PIX_MAX  = '1;
    localparam logic [LINE_W-1:0] LINE_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_t;

    // Saturating increments; the top bit flags that the counter sits at its maximum.
    function automatic logic [PIX_W:0] inc_p(input logic [PIX_W-1:0] v, input logic en);
        logic [PIX_W-1:0] n;
        n = (en && (v != PIX_MAX)) ? v + PIX_W'(1) : v;
        return {en && (n == PIX_MAX), n};
    endfunction

    function automatic logic [LINE_W:0] inc_l(input logic [LINE_W-1:0] v, input logic en);
        logic [LINE_W-1:0] n;
        n = (en && (v != LINE_MAX)) ? v + LINE_W'(1) : v;
        return {en && (n == LINE_MAX), n};
    endfunction

    state_t              state_q, state_nx_c;
    logic                vga_clk_q, hs_q, vs_q;
    logic [PIX_W-1:0]    pix_cnt, hs_cnt, act_cnt;
    logic [PIX_W-1:0]    htotal_w, hsync_w, hact_max;
    logic [LINE_W-1:0]   line_cnt, vact_cnt, vs_lines;
    logic [CSUM_W-1:0]   csum;
    logic [PIX_W-1:0]    sh_htotal, sh_hactive, sh_hsync;
    logic [LINE_W-1:0]   sh_vtotal, sh_vactive, sh_vsync;
    logic [CSUM_W-1:0]   sh_csum;
    logic [15:0]         frame_count;
    logic                frame_done, locked, overflow, have_pub;

    logic                pix_ev_c, hs_fall_c, vs_fall_c, publish_c, geom_same_c, ovf_hit_c;
    logic [9:0]          rgb_sum_c;
    logic [PIX_W:0]      p_r, h_r, a_r;
    logic [LINE_W:0]     l_r, va_r, vs_r;
    logic [PIX_W-1:0]    pix_nx_c, hs_nx_c, act_nx_c, hmax_cl_c, htotal_pub_c, hsync_pub_c;
    logic [LINE_W-1:0]   line_cl_c, vact_cl_c, vsl_cl_c;
    logic [CSUM_W-1:0]   csum_cl_c;
    logic [31:0]         csum32_c;
    logic [15:0]         rd_mux_c;

    assign pix_ev_c  = vga_clk & ~vga_clk_q;
    assign hs_fall_c = pix_ev_c & hs_q & ~vga_hs;
    assign vs_fall_c = pix_ev_c & vs_q & ~vga_vs;
    assign rgb_sum_c = 10'(vga_r) + 10'(vga_g) + 10'(vga_b);

    // Next line state and the frame accumulators after any line close on this pixel.
    always_comb begin
        p_r  = inc_p(pix_cnt, 1'b1);
        h_r  = inc_p(hs_cnt, ~vga_hs);
        a_r  = inc_p(act_cnt, vga_blank_n);
        l_r  = inc_l(line_cnt, 1'b1);
        va_r = inc_l(vact_cnt, act_cnt != '0);
        vs_r = inc_l(vs_lines, ~vga_vs);

        pix_nx_c     = p_r[PIX_W-1:0];
        hs_nx_c      = h_r[PIX_W-1:0];
        act_nx_c     = a_r[PIX_W-1:0];
        hmax_cl_c    = hact_max;
        line_cl_c    = line_cnt;
        vact_cl_c    = vact_cnt;
        vsl_cl_c     = vs_lines;
        htotal_pub_c = htotal_w;
        hsync_pub_c  = hsync_w;
        ovf_hit_c    = p_r[PIX_W] | h_r[PIX_W] | a_r[PIX_W];

        if (hs_fall_c) begin
            pix_nx_c     = PIX_W'(1);
            hs_nx_c      = PIX_W'(1);
            act_nx_c     = PIX_W'(vga_blank_n);
            hmax_cl_c    = (act_cnt > hact_max) ? act_cnt : hact_max;
            line_cl_c    = l_r[LINE_W-1:0];
            vact_cl_c    = va_r[LINE_W-1:0];
            vsl_cl_c     = vs_r[LINE_W-1:0];
            htotal_pub_c = pix_cnt;
            hsync_pub_c  = hs_cnt;
            ovf_hit_c    = l_r[LINE_W] | va_r[LINE_W] | vs_r[LINE_W];
        end

        csum_cl_c = csum + (vga_blank_n ? CSUM_W'(rgb_sum_c) : CSUM_W'(0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_clk_q <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            pix_cnt   <= '0;
            hs_cnt    <= '0;
            act_cnt   <= '0;
            htotal_w  <= '0;
            hsync_w   <= '0;
            overflow  <= 1'b0;
        end else begin
            vga_clk_q <= vga_clk;
            if (pix_ev_c) begin
                hs_q    <= vga_hs;
                vs_q    <= vga_vs;
                pix_cnt <= pix_nx_c;
                hs_cnt  <= hs_nx_c;
                act_cnt <= act_nx_c;
                if (hs_fall_c) begin
                    htotal_w <= pix_cnt;
                    hsync_w  <= hs_cnt;
                end
                if (ovf_hit_c) overflow <= 1'b1;
            end
        end
    end

    // Frame accumulators restart on every VS fall, after the coincident line close was folded in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hact_max <= '0;
            line_cnt <= '0;
            vact_cnt <= '0;
            vs_lines <= '0;
            csum     <= '0;
        end else if (pix_ev_c) begin
            if (vs_fall_c) begin
                hact_max <= '0;
                line_cnt <= '0;
                vact_cnt <= '0;
                vs_lines <= '0;
                csum     <= '0;
            end else begin
                hact_max <= hmax_cl_c;
                line_cnt <= line_cl_c;
                vact_cnt <= vact_cl_c;
                vs_lines <= vsl_cl_c;
                csum     <= csum_cl_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_nx_c;
    end

    always_comb begin
        state_nx_c = state_q;
        publish_c  = 1'b0;
        case (state_q)
            ST_IDLE:  if (vs_fall_c) state_nx_c = ST_ARMED;
            ST_ARMED: if (vs_fall_c) begin
                state_nx_c = ST_RUN;
                publish_c  = 1'b1;
            end
            ST_RUN:   if (vs_fall_c) publish_c = 1'b1;
            default:  state_nx_c = ST_IDLE;
        endcase
    end

    assign geom_same_c = have_pub &&
                         (htotal_pub_c == sh_htotal) && (hmax_cl_c == sh_hactive) &&
                         (hsync_pub_c == sh_hsync)   && (line_cl_c == sh_vtotal) &&
                         (vact_cl_c == sh_vactive)   && (vsl_cl_c == sh_vsync);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_htotal   <= '0;
            sh_hactive  <= '0;
            sh_hsync    <= '0;
            sh_vtotal   <= '0;
            sh_vactive  <= '0;
            sh_vsync    <= '0;
            sh_csum     <= '0;
            frame_count <= '0;
            locked      <= 1'b0;
            have_pub    <= 1'b0;
        end else if (publish_c) begin
            sh_htotal   <= htotal_pub_c;
            sh_hactive  <= hmax_cl_c;
            sh_hsync    <= hsync_pub_c;
            sh_vtotal   <= line_cl_c;
            sh_vactive  <= vact_cl_c;
            sh_vsync    <= vsl_cl_c;
            sh_csum     <= csum_cl_c;
            frame_count <= frame_count + 16'd1;
            locked      <= geom_same_c;
            have_pub    <= 1'b1;
        end
    end

    assign csum32_c = 32'(sh_csum);

    always_comb begin
        rd_mux_c = '0;
        case (address)
            4'd0:    rd_mux_c = {13'b0, overflow, locked, frame_done};
            4'd1:    rd_mux_c = frame_count;
            4'd2:    rd_mux_c = 16'(sh_htotal);
            4'd3:    rd_mux_c = 16'(sh_hactive);
            4'd4:    rd_mux_c = 16'(sh_hsync);
            4'd5:    rd_mux_c = 16'(sh_vtotal);
            4'd6:    rd_mux_c = 16'(sh_vactive);
            4'd7:    rd_mux_c = 16'(sh_vsync);
            4'd8:    rd_mux_c = csum32_c[15:0];
            4'd9:    rd_mux_c = csum32_c[31:16];
            default: rd_mux_c = '0;
        endcase
    end

    // A status read clears frame_done, but a coincident publish keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata   <= '0;
            frame_done <= 1'b0;
        end else begin
            if (chipselect && read) readdata <= rd_mux_c;
            if (publish_c)
                frame_done <= 1'b1;
            else if (chipselect && read && (address == 4'd0))
                frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Bench for vga_frame_monitor: drives a small raster, predicts each snapshot analytically from the
// frame's geometry and colours, and checks readdata every cycle plus hand-computed register values.
module tb_vga_frame_monitor;

    localparam int HT = 44, HA = 32, HSS = 34, HSE = 40;
    localparam int VT = 30, VA = 24, VSS = 26, VSE = 29;
    localparam int SQ0 = 8, SQ1 = 12, SQN = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_clk, vga_hs, vga_vs, vga_blank_n;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        chipselect, read;
    logic [3:0]  address;
    logic [15:0] readdata;

    always #10 clk = ~clk;

    vga_frame_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .vga_clk    (vga_clk),
        .vga_hs     (vga_hs),
        .vga_vs     (vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .chipselect (chipselect),
        .read       (read),
        .address    (address),
        .readdata   (readdata)
    );

    // Reference snapshot state
    int          m_vsf, m_pubs;
    logic        m_done, m_locked, m_ovf;
    logic [15:0] m_fc, m_ht, m_ha, m_hs, m_vt, m_va, m_vsw;
    logic [31:0] m_csum;

    int          n_cmp = 0, n_err = 0;
    logic        chk_en = 1'b0;
    logic [15:0] exp_rd = '0;
    logic        lit_pend = 1'b0;
    logic [15:0] lit_exp = '0;
    string       lit_nm = "";
    logic        want_en = 1'b0;
    logic [15:0] want_val = '0;
    string       want_nm = "";

    function automatic logic [15:0] model_reg(input logic [3:0] a);
        case (a)
            4'd0:    return {13'b0, m_ovf, m_locked, m_done};
            4'd1:    return m_fc;
            4'd2:    return m_ht;
            4'd3:    return m_ha;
            4'd4:    return m_hs;
            4'd5:    return m_vt;
            4'd6:    return m_va;
            4'd7:    return m_vsw;
            4'd8:    return m_csum[15:0];
            4'd9:    return m_csum[31:16];
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            exp_rd   = '0;
            lit_pend = 1'b0;
        end else begin
            lit_pend = 1'b0;
            if (chipselect && read) begin
                exp_rd   = model_reg(address);
                lit_pend = want_en;
                lit_exp  = want_val;
                lit_nm   = want_nm;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && chk_en) begin
            n_cmp++;
            if (readdata !== exp_rd) begin
                n_err++;
                $display("FAIL readdata_model t=%0t got=%h want=%h", $time, readdata, exp_rd);
            end
            if (lit_pend) begin
                n_cmp++;
                if (readdata !== lit_exp) begin
                    n_err++;
                    $display("FAIL %s t=%0t got=%h want=%h", lit_nm, $time, readdata, lit_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        chipselect = 1'b0;
        read = 1'b0;
        m_vsf = 0; m_pubs = 0;
        m_done = 1'b0; m_locked = 1'b0; m_ovf = 1'b0;
        m_fc = '0; m_ht = '0; m_ha = '0; m_hs = '0; m_vt = '0; m_va = '0; m_vsw = '0;
        m_csum = '0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        address = a; chipselect = 1'b1; read = 1'b1;
        tick();
        chipselect = 1'b0; read = 1'b0;
        if (a == 4'd0) m_done = 1'b0;
    endtask

    task automatic rd_lit(input logic [3:0] a, input logic [15:0] v, input string nm);
        want_en = 1'b1; want_val = v; want_nm = nm;
        rd(a);
        want_en = 1'b0;
    endtask

    // Snapshot of the VS-to-VS period is known from the frame's geometry and colours alone.
    task automatic vs_fall(input int extra, input int bg_sum);
        int          ht;
        logic [15:0] ht16;
        m_vsf++;
        if (m_vsf < 2) return;
        ht   = (HT + extra > 2047) ? 2047 : HT + extra;
        ht16 = 16'(ht);
        m_locked = (m_pubs > 0) && (ht16 == m_ht) && (m_ha == 16'(HA)) && (m_hs == 16'(HSE - HSS)) &&
                   (m_vt == 16'(VT)) && (m_va == 16'(VA)) && (m_vsw == 16'(VSE - VSS));
        m_ht   = ht16;
        m_ha   = 16'(HA);
        m_hs   = 16'(HSE - HSS);
        m_vt   = 16'(VT);
        m_va   = 16'(VA);
        m_vsw  = 16'(VSE - VSS);
        m_csum = 32'((HA * VA - SQN) * bg_sum + SQN * 765);
        m_fc   = m_fc + 16'd1;
        m_done = 1'b1;
        m_pubs++;
    endtask

    task automatic pixel(input logic hs, input logic vs, input logic bl,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic rd0);
        vga_clk = 1'b0; vga_hs = hs; vga_vs = vs; vga_blank_n = bl;
        vga_r = r; vga_g = g; vga_b = b;
        tick();
        vga_clk = 1'b1;
        if (rd0) begin address = 4'd0; chipselect = 1'b1; read = 1'b1; end
        tick();
        chipselect = 1'b0; read = 1'b0;
        if (rd0) m_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] br, input logic [7:0] bg, input logic [7:0] bb,
                         input int extra, input int stuck_row, input int reset_row, input logic rd_at_vs);
        int w;
        logic hs, vs, bl, sq;
        logic [7:0] r, g, b;
        for (int y = 0; y < VT; y++) begin
            w = (y == VSS - 2) ? HT + extra : HT;
            for (int x = 0; x < w; x++) begin
                hs = !(x >= HSS && x < HSE);
                vs = !(y >= VSS && y < VSE);
                bl = (y < VA) && (x < HA);
                sq = (x >= SQ0) && (x < SQ1) && (y >= SQ0) && (y < SQ1);
                r = bl ? (sq ? 8'hff : br) : 8'h00;
                g = bl ? (sq ? 8'hff : bg) : 8'h00;
                b = bl ? (sq ? 8'hff : bb) : 8'h00;
                pixel(hs, vs, bl, r, g, b, rd_at_vs && (y == VSS) && (x == 0));
                if (y == VSS && x == 0) vs_fall(extra, int'(br) + int'(bg) + int'(bb));
                if (y == stuck_row && x == 10) begin
                    vga_hs = 1'b0; vga_vs = 1'b0; vga_blank_n = 1'b1;
                    vga_r = 8'hff; vga_g = 8'hff; vga_b = 8'hff;
                    repeat (4200) tick();
                end
                if (y == reset_row && x == 5) begin
                    do_reset();
                    for (int a = 0; a < 16; a++) rd_lit(4'(a), 16'h0, "midframe_reset_reg");
                end
            end
            if (y == VSS - 2 && HT + extra >= 2047) m_ovf = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; vga_clk = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank_n = 1'b0;
        vga_r = '0; vga_g = '0; vga_b = '0; chipselect = 1'b0; read = 1'b0; address = '0;
        do_reset();
        chk_en = 1'b1;
        for (int a = 0; a < 16; a++) rd_lit(4'(a), 16'h0, "reset_reg");

        frame(8'h00, 8'h00, 8'h80, 0, -1, -1, 1'b0);
        rd_lit(4'd0, 16'h0, "one_vs_status");
        rd_lit(4'd1, 16'h0, "one_vs_count");

        frame(8'h00, 8'h00, 8'h80, 0, -1, -1, 1'b0);
        rd_lit(4'd0, 16'h1, "pub1_status");
        rd_lit(4'd0, 16'h0, "status_cleared");
        rd_lit(4'd1, 16'h1, "pub1_count");

        frame(8'h00, 8'h00, 8'h80, 0, -1, -1, 1'b0);
        rd_lit(4'd0, 16'h3, "pub2_status");
        rd_lit(4'd0, 16'h2, "pub2_status_cleared");
        rd_lit(4'd1, 16'd2, "pub2_count");
        rd_lit(4'd2, 16'd44, "htotal");
        rd_lit(4'd3, 16'd32, "hactive");
        rd_lit(4'd4, 16'd6, "hsync");
        rd_lit(4'd5, 16'd30, "vtotal");
        rd_lit(4'd6, 16'd24, "vactive");
        rd_lit(4'd7, 16'd3, "vsync");
        rd_lit(4'd8, 16'hA7D0, "csum_lo");
        rd_lit(4'd9, 16'h0001, "csum_hi");

        want_en = 1'b1; want_val = 16'h2; want_nm = "coincident_read";
        frame(8'h10, 8'h20, 8'h30, 0, 5, -1, 1'b1);
        want_en = 1'b0;
        rd_lit(4'd0, 16'h3, "after_coincident_status");
        rd_lit(4'd1, 16'd3, "stuck_count");
        rd_lit(4'd2, 16'd44, "stuck_htotal");
        rd_lit(4'd8, 16'h49D0, "bg_csum_lo");
        rd_lit(4'd9, 16'h0001, "bg_csum_hi");

        frame(8'h00, 8'h00, 8'h80, 1, -1, -1, 1'b0);
        rd_lit(4'd2, 16'd45, "stretch_htotal");
        rd_lit(4'd0, 16'h1, "stretch_status");
        frame(8'h00, 8'h00, 8'h80, 0, -1, -1, 1'b0);
        rd_lit(4'd0, 16'h1, "relock_first");
        frame(8'h00, 8'h00, 8'h80, 0, -1, -1, 1'b0);
        rd_lit(4'd0, 16'h3, "relock_second");
        rd_lit(4'd2, 16'd44, "relock_htotal");

        frame(8'h00, 8'h00, 8'h80, 2100, -1, -1, 1'b0);
        rd_lit(4'd2, 16'd2047, "sat_htotal");
        rd_lit(4'd0, 16'h5, "sat_status");
        frame(8'h00, 8'h00, 8'h80, 0, -1, -1, 1'b0);
        rd_lit(4'd0, 16'h5, "overflow_sticky");

        frame(8'h00, 8'h00, 8'h80, 0, -1, 10, 1'b0);
        rd_lit(4'd0, 16'h0, "rearm_status");
        rd_lit(4'd1, 16'h0, "rearm_count");
        frame(8'h00, 8'h00, 8'h80, 0, -1, -1, 1'b0);
        rd_lit(4'd0, 16'h1, "republish_status");
        rd_lit(4'd1, 16'd1, "republish_count");
        rd_lit(4'd5, 16'd30, "republish_vtotal");
        rd_lit(4'd8, 16'hA7D0, "republish_csum_lo");

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
